// File: rtl/prio_encoder_pkg.sv
// Shared widths and types for the priority encoder slice.
package prio_encoder_pkg;

   localparam int REQ_W = 8;
   localparam int IDX_W = 3;

   typedef logic [REQ_W-1:0] req_t;
   typedef logic [IDX_W-1:0] idx_t;

   // One-hot mask for a single index, used to retire an issued request.
   function automatic req_t idx_onehot(input idx_t i);
      return req_t'(1) << i;
   endfunction

endpackage

// File: rtl/prio_encoder_pick.sv
// prio_pick: combinational search for the first set bit of vec, starting at
// start and moving upward with wrap from index 7 to index 0. Passing start=0
// gives plain lowest-index-wins priority.
module prio_pick
   import prio_encoder_pkg::*;
(
   input  logic [REQ_W-1:0] vec,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   idx_t cand;

   // Walk the rotated order once; the first hit wins and later hits are ignored.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < REQ_W; i++) begin
         cand = start + idx_t'(i);
         if (!found && vec[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_encoder.sv
// prio_encoder: collects requests into a pending set and issues one index per
// accepted output beat through a registered valid/ready output stage.
// Build option: define PRIO_ENCODER_ROUND_ROBIN_EN for round-robin arbitration
// (rotating search pointer); leave undefined for fixed lowest-index priority.
module prio_encoder
   import prio_encoder_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REQ_W-1:0] in,
   input  logic             in_valid,
   output logic [IDX_W-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   req_t pending_q, pending_d;
   idx_t out_q,     out_d;
   logic out_valid_q, out_valid_d;

   idx_t search_start;
   idx_t pick_idx;
   logic pick_found;
   logic load;

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
   idx_t ptr_q, ptr_d;

   assign search_start = ptr_q;

   // Pointer moves just past the index that was issued, so it loses priority next time.
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = pick_idx + idx_t'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign search_start = '0;
`endif

   prio_pick u_pick (
      .vec   (pending_q),
      .start (search_start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // pick_found is exactly (pending_q != 0); loading looks only at registered
   // pending, so a fresh request always costs one cycle in the pending set.
   assign load = (!out_valid_q || out_ready) && pick_found;

   // Retire the issued bit first, then OR in new requests so a coincident set wins.
   always_comb begin
      pending_d = pending_q;
      if (load) begin
         pending_d = pending_d & ~idx_onehot(pick_idx);
      end
      if (in_valid) begin
         pending_d = pending_d | in;
      end
   end

   // Output stage: load a new index, drop valid on an accept with nothing to load, else hold.
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (load) begin
         out_d       = pick_idx;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Pending set and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q   <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = (pending_q != '0) || out_valid_q;

endmodule

// File: tb/tb_prio_encoder.sv
// Directed bench for prio_encoder. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point. Each check compares the
// packed triple {out_valid, out, busy}.
module tb_prio_encoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_s;
   logic       in_valid;
   logic [2:0] out_s;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   int nvec;
   int nerr;

   logic [4:0] got;

   prio_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_s),
      .in_valid  (in_valid),
      .out       (out_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      got = {out_valid, out_s, busy};
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_s     = 8'h00;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_s      = 8'hFF;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      nvec++;
      if (got !== {1'b0, 3'd0, 1'b0}) begin
         nerr++; $display("FAIL reset_state got %b want %b", got, {1'b0, 3'd0, 1'b0});
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_s     = 8'h00;
      for (int i = 0; i < 2; i++) begin
         step();
         nvec++;
         if (got !== {1'b0, 3'd0, 1'b0}) begin
            nerr++; $display("FAIL reset_ignore_in[%0d] got %b want %b", i, got, {1'b0, 3'd0, 1'b0});
         end
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_s      = 8'b0000_0001;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      in_s     = 8'h00;
      nvec++;
      if (got !== {1'b0, 3'd0, 1'b1}) begin
         nerr++; $display("FAIL single_latency got %b want %b", got, {1'b0, 3'd0, 1'b1});
      end
      step();
      nvec++;
      if (got !== {1'b1, 3'd0, 1'b1}) begin
         nerr++; $display("FAIL single_issue got %b want %b", got, {1'b1, 3'd0, 1'b1});
      end
      step();
      nvec++;
      if (got !== {1'b0, 3'd0, 1'b0}) begin
         nerr++; $display("FAIL single_idle got %b want %b", got, {1'b0, 3'd0, 1'b0});
      end
   endtask

   task automatic test_null_request();
      in_s     = 8'h00;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         nvec++;
         if (got !== {1'b0, 3'd0, 1'b0}) begin
            nerr++; $display("FAIL null_req[%0d] got %b want %b", i, got, {1'b0, 3'd0, 1'b0});
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_multi_hot();
      logic [4:0] exp_seq [4];
      exp_seq[0] = {1'b1, 3'd2, 1'b1};
      exp_seq[1] = {1'b1, 3'd5, 1'b1};
      exp_seq[2] = {1'b1, 3'd7, 1'b1};
      exp_seq[3] = {1'b0, 3'd7, 1'b0};
      out_ready = 1'b1;
      in_s      = 8'b1010_0100;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      in_s     = 8'h00;
      nvec++;
      if (got !== {1'b0, 3'd0, 1'b1}) begin
         nerr++; $display("FAIL multi_pending got %b want %b", got, {1'b0, 3'd0, 1'b1});
      end
      for (int i = 0; i < 4; i++) begin
         step();
         nvec++;
         if (got !== exp_seq[i]) begin
            nerr++; $display("FAIL multi_seq[%0d] got %b want %b", i, got, exp_seq[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_s      = 8'b0000_1100;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      in_s     = 8'h00;
      nvec++;
      if (got !== {1'b0, 3'd7, 1'b1}) begin
         nerr++; $display("FAIL bp_pending got %b want %b", got, {1'b0, 3'd7, 1'b1});
      end
      step();
      nvec++;
      if (got !== {1'b1, 3'd2, 1'b1}) begin
         nerr++; $display("FAIL bp_first got %b want %b", got, {1'b1, 3'd2, 1'b1});
      end
      for (int i = 0; i < 4; i++) begin
         // Re-request the still-pending index 3 once; it must merge, not duplicate.
         in_s     = (i == 1) ? 8'b0000_1000 : 8'h00;
         in_valid = (i == 1);
         step();
         in_valid = 1'b0;
         in_s     = 8'h00;
         if (i >= 2) begin
            nvec++;
            if (got !== {1'b1, 3'd2, 1'b1}) begin
               nerr++; $display("FAIL bp_hold[%0d] got %b want %b", i, got, {1'b1, 3'd2, 1'b1});
            end
         end
      end
      nvec++;
      if (got !== {1'b1, 3'd2, 1'b1}) begin
         nerr++; $display("FAIL bp_hold_end got %b want %b", got, {1'b1, 3'd2, 1'b1});
      end
      out_ready = 1'b1;
      step();
      nvec++;
      if (got !== {1'b1, 3'd3, 1'b1}) begin
         nerr++; $display("FAIL bp_release got %b want %b", got, {1'b1, 3'd3, 1'b1});
      end
      step();
      nvec++;
      if (got !== {1'b0, 3'd3, 1'b0}) begin
         nerr++; $display("FAIL bp_drain got %b want %b", got, {1'b0, 3'd3, 1'b0});
      end
   endtask

   task automatic test_collision();
      out_ready = 1'b1;
      in_s      = 8'b0000_0010;
      in_valid  = 1'b1;
      step();
      nvec++;
      if (got !== {1'b0, 3'd3, 1'b1}) begin
         nerr++; $display("FAIL coll_pending got %b want %b", got, {1'b0, 3'd3, 1'b1});
      end
      step();
      in_valid = 1'b0;
      in_s     = 8'h00;
      nvec++;
      if (got !== {1'b1, 3'd1, 1'b1}) begin
         nerr++; $display("FAIL coll_first got %b want %b", got, {1'b1, 3'd1, 1'b1});
      end
      step();
      nvec++;
      if (got !== {1'b1, 3'd1, 1'b1}) begin
         nerr++; $display("FAIL coll_second got %b want %b", got, {1'b1, 3'd1, 1'b1});
      end
      step();
      nvec++;
      if (got !== {1'b0, 3'd1, 1'b0}) begin
         nerr++; $display("FAIL coll_idle got %b want %b", got, {1'b0, 3'd1, 1'b0});
      end
   endtask

   task automatic test_arbitration();
      logic [2:0] exp_idx;
      apply_reset();
      out_ready = 1'b1;
      in_s      = 8'b1000_0001;
      in_valid  = 1'b1;
      step();
      nvec++;
      if (got !== {1'b0, 3'd0, 1'b1}) begin
         nerr++; $display("FAIL arb_pending got %b want %b", got, {1'b0, 3'd0, 1'b1});
      end
      for (int i = 0; i < 4; i++) begin
         step();
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
         exp_idx = (i % 2 == 0) ? 3'd0 : 3'd7;
`else
         exp_idx = 3'd0;
`endif
         nvec++;
         if (got !== {1'b1, exp_idx, 1'b1}) begin
            nerr++; $display("FAIL arb_seq[%0d] got %b want %b", i, got, {1'b1, exp_idx, 1'b1});
         end
      end
      in_valid = 1'b0;
      in_s     = 8'h00;
      for (int i = 0; i < 4; i++) step();
      nvec++;
      if (got !== {1'b0, 3'd7, 1'b0}) begin
         nerr++; $display("FAIL arb_drain got %b want %b", got, {1'b0, 3'd7, 1'b0});
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_s      = 8'b0101_0010;
      in_valid  = 1'b1;
      step();
      in_s = 8'b0000_0010;
      step();
      in_valid = 1'b0;
      in_s     = 8'h00;
      nvec++;
      if (got !== {1'b1, 3'd1, 1'b1}) begin
         nerr++; $display("FAIL mid_loaded got %b want %b", got, {1'b1, 3'd1, 1'b1});
      end
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      nvec++;
      if (got !== {1'b0, 3'd0, 1'b0}) begin
         nerr++; $display("FAIL mid_reset got %b want %b", got, {1'b0, 3'd0, 1'b0});
      end
      for (int i = 0; i < 3; i++) begin
         step();
         nvec++;
         if (got !== {1'b0, 3'd0, 1'b0}) begin
            nerr++; $display("FAIL mid_quiet[%0d] got %b want %b", i, got, {1'b0, 3'd0, 1'b0});
         end
      end
   endtask

   initial begin
      nvec      = 0;
      nerr      = 0;
      rst_n     = 1'b0;
      in_s      = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      got       = '0;
      test_reset();
      test_single();
      test_null_request();
      test_multi_hot();
      test_backpressure();
      test_collision();
      test_arbitration();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/prio_encoder.md
PRIO_ENCODER -- requirements
Module: prio_encoder

Interface
REQ-001 Parameters: none; the request width is fixed at 8 and the index width at 3.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in  input  8  request vector; bit i requests index i; multi-hot is legal.
REQ-005 in_valid  input  1  qualifies in for the current cycle.
REQ-006 out  output  3  encoded index of the issued request; registered.
REQ-007 out_valid  output  1  out holds a valid index; registered.
REQ-008 out_ready  input  1  consumer accepts out when out_valid && out_ready.
REQ-009 busy  output  1  equals (pending != 0) || out_valid.

Function
REQ-010 An internal 8-bit pending register shall hold requested indices not yet issued.
REQ-011 Each edge with in_valid=1 shall OR in into pending; in_valid=1 with in=0 shall have no effect.
REQ-012 A request for an index already pending shall merge with it, with no count and no duplicate issue.
REQ-013 The load condition shall be (!out_valid || out_ready) && (pending != 0), evaluated on registered pending only.
REQ-014 On load, out shall take the selected index, out_valid shall go to 1, and that pending bit shall clear.
REQ-015 If in_valid && in[idx] coincides with the load of idx, the set shall win and idx stays pending for a later issue.
REQ-016 When out_valid && out_ready and no load occurs, out_valid shall go to 0; out keeps its last value.
REQ-017 While out_valid && !out_ready, out and out_valid shall hold stable.
REQ-018 Latency: in_valid sampled at edge k shall give out_valid=1 no earlier than after edge k+1, i.e. 2 cycles from request to index.
REQ-019 Throughput: with out_ready held at 1, one index shall issue per cycle.
REQ-020 Selection, default: fixed priority, where the lowest set pending index wins.

Reset
REQ-021 When rst_n=0 at an edge, the block shall set out=3'b000, out_valid=0, pending=8'h00 and ptr=3'b000.
REQ-022 A reset mid-operation shall drop all pending and presented requests without issuing them.
REQ-023 in and in_valid shall be ignored during the reset cycle.

Configuration
REQ-024 Macro PRIO_ENCODER_ROUND_ROBIN_EN shall select the arbitration mode.
- Defined: a 3-bit pointer ptr is added; the search starts at ptr and proceeds upward, wrapping 7 to 0.
- On each load, ptr becomes (idx+1) mod 8.
- Undefined: no ptr exists and fixed priority per REQ-020 applies.
REQ-025 Interface, latency and handshake shall be identical in both builds.

Structure
REQ-026 Package prio_encoder_pkg shall hold REQ_W=8, IDX_W=3, and the typedefs req_t [7:0] and idx_t [2:0].
REQ-027 Combinational sub-module prio_pick shall take (req_t vec, idx_t start) and return (idx_t idx, found).
- Fixed priority ties start to 0.
REQ-028 prio_encoder shall contain only the pending, output and ptr registers plus control logic.

Verification
REQ-029 Single request: reset, then in=8'b00000001 with in_valid for 1 cycle and out_ready=1 -> out=3'b000, out_valid high for exactly 1 cycle, 2 cycles after the request; then busy=0.
REQ-030 Multi-hot, fixed build: in=8'b10100100 for 1 cycle, out_ready=1 -> out=2, 5, 7 on consecutive cycles, then out_valid=0 and busy=0.
REQ-031 Backpressure: pending 8'b00001100, out_ready=0 for 4 cycles -> out=2 stable with out_valid=1. Release out_ready -> out=3 on the next cycle, then out_valid=0.
REQ-032 Set-wins collision: in=8'b00000010 asserted on the same edge that loads index 1 -> index 1 issued twice, back-to-back.
REQ-033 Arbitration: in=8'b10000001 every cycle, out_ready=1.
- PRIO_ENCODER_ROUND_ROBIN_EN defined -> out alternates 0, 7, 0, 7.
- Macro undefined -> out=0 every cycle and 7 is never issued.
REQ-034 Reset mid-operation: pending=8'b01010010 with out_valid=1, rst_n=0 for 1 cycle -> next cycle out_valid=0, out=0, busy=0. Nothing issues afterwards without new requests.
